// File: rtl/eu_dispatch_if.sv
// ---------------------------------------------------------------------------
// eu_dispatch_if
// Bundles the front-end instruction stream, the EU ready/dispatch bus and
// the status outputs of eu_dispatch.
//   master : the environment side (front end + execution units)
//   slave  : the dispatcher itself
// Signals:
//   instr_i / instr_hint_valid_i / instr_hint_i / instr_valid_i  front-end stream
//   instr_ready_o            dispatcher can accept an instruction this cycle
//   flush_i                  discard buffered and pending work
//   eu_ready_i               per-EU "can accept next cycle"
//   dispatched_instr_o       shared instruction bus to all EUs
//   dispatched_instr_valid_o one-hot per-EU qualifier
//   occupancy_o              buffered entries (0..2)
//   dispatch_err_o           sticky out-of-range hint flag
// ---------------------------------------------------------------------------
interface eu_dispatch_if #(
    parameter int N_EU     = 4,
    parameter int EU_IDX_W = 2,
    parameter int INSTR_W  = 64
);
    logic [INSTR_W-1:0]  instr_i;
    logic                instr_hint_valid_i;
    logic [EU_IDX_W-1:0] instr_hint_i;
    logic                instr_valid_i;
    logic                instr_ready_o;
    logic                flush_i;
    logic [N_EU-1:0]     eu_ready_i;
    logic [INSTR_W-1:0]  dispatched_instr_o;
    logic [N_EU-1:0]     dispatched_instr_valid_o;
    logic [1:0]          occupancy_o;
    logic                dispatch_err_o;

    modport master (
        output instr_i, instr_hint_valid_i, instr_hint_i, instr_valid_i,
        output flush_i, eu_ready_i,
        input  instr_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
        input  occupancy_o, dispatch_err_o
    );

    modport slave (
        input  instr_i, instr_hint_valid_i, instr_hint_i, instr_valid_i,
        input  flush_i, eu_ready_i,
        output instr_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
        output occupancy_o, dispatch_err_o
    );
endinterface

// File: rtl/eu_dispatch.sv
// ---------------------------------------------------------------------------
// eu_dispatch
// Feeds the execution units from the renamed-instruction stream. Incoming
// instructions land in a 2-entry in-order buffer; each cycle the head entry
// is sent to at most one EU: its pinned EU when it carries an in-range hint,
// otherwise the first ready EU in round-robin order from rr_ptr. The
// dispatched instruction and its one-hot valid are registered, so they are
// visible the cycle after selection.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      eu_dispatch_if.slave (stream in, EU bus out, status out)
// ---------------------------------------------------------------------------
module eu_dispatch #(
    parameter int N_EU     = 4,
    parameter int EU_IDX_W = 2,
    parameter int INSTR_W  = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    eu_dispatch_if.slave  bus
);

    // N_EU at hint width + 1, so a hint can be range-checked without
    // losing the out-of-range values the hint field can encode.
    localparam logic [EU_IDX_W:0] LP_N_EU = (EU_IDX_W+1)'(N_EU);

    // Buffer storage, entry 0 is the head
    logic [INSTR_W-1:0]  r_instr_p0 [2];
    logic                r_hv_p0    [2];
    logic [EU_IDX_W-1:0] r_hint_p0  [2];

    logic [1:0]          r_occ;
    logic [EU_IDX_W-1:0] r_rr;
    logic                r_err;
    logic [N_EU-1:0]     r_disp_vld_p1;
    logic [INSTR_W-1:0]  r_disp_instr_p1;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_head_vld;
    logic                w_hint_bad;
    logic                w_pinned;
    logic                w_sel_vld;
    logic [EU_IDX_W-1:0] w_tgt;
    logic [EU_IDX_W-1:0] w_rr_nxt;
    logic [N_EU-1:0]     w_onehot;

    assign w_ready = (r_occ != 2'd2);
    // A push during flush is dropped along with the buffer contents.
    assign w_push  = bus.instr_valid_i && w_ready && !bus.flush_i;
    assign w_pop   = w_sel_vld;

    // Stage p0: head-entry target selection
    always_comb begin
        int v_dist;
        int v_best;
        w_head_vld = (r_occ != 2'd0);
        w_hint_bad = w_head_vld && r_hv_p0[0] && ({1'b0, r_hint_p0[0]} >= LP_N_EU);
        // A malformed hint degrades to an unpinned entry.
        w_pinned   = w_head_vld && r_hv_p0[0] && !w_hint_bad;
        w_sel_vld  = 1'b0;
        w_tgt      = '0;
        v_dist     = 0;
        v_best     = N_EU;
        for (int k = 0; k < N_EU; k++) begin
            if (w_pinned) begin
                if (r_hint_p0[0] == EU_IDX_W'(k) && bus.eu_ready_i[k]) begin
                    w_sel_vld = 1'b1;
                    w_tgt     = EU_IDX_W'(k);
                end
            end else if (w_head_vld && bus.eu_ready_i[k]) begin
                // Distance from rr_ptr going upward with wrap; nearest wins.
                v_dist = k - int'(r_rr);
                if (v_dist < 0) v_dist = v_dist + N_EU;
                if (v_dist < v_best) begin
                    v_best    = v_dist;
                    w_sel_vld = 1'b1;
                    w_tgt     = EU_IDX_W'(k);
                end
            end
        end
        for (int k = 0; k < N_EU; k++) begin
            w_onehot[k] = w_sel_vld && (w_tgt == EU_IDX_W'(k));
        end
        if (w_tgt == EU_IDX_W'(N_EU - 1)) w_rr_nxt = '0;
        else                              w_rr_nxt = w_tgt + EU_IDX_W'(1);
    end

    // Stage p0 -> p1: control state and registered dispatch outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ           <= 2'd0;
            r_rr            <= '0;
            r_err           <= 1'b0;
            r_disp_vld_p1   <= '0;
            r_disp_instr_p1 <= '0;
        end else begin
            if (w_hint_bad) r_err <= 1'b1;
            if (bus.flush_i) begin
                r_occ         <= 2'd0;
                r_disp_vld_p1 <= '0;
            end else begin
                r_occ         <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
                r_disp_vld_p1 <= w_onehot;
                if (w_sel_vld) begin
                    r_disp_instr_p1 <= r_instr_p0[0];
                    if (!w_pinned) r_rr <= w_rr_nxt;
                end
            end
        end
    end

    // Buffer payload; validity is carried by r_occ alone.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_instr_p0[0] <= r_instr_p0[1];
            r_hv_p0[0]    <= r_hv_p0[1];
            r_hint_p0[0]  <= r_hint_p0[1];
        end
        if (w_push) begin
            // Write slot is the post-pop tail; overrides the shift above.
            if (r_occ == 2'd0 || (r_occ == 2'd1 && w_pop)) begin
                r_instr_p0[0] <= bus.instr_i;
                r_hv_p0[0]    <= bus.instr_hint_valid_i;
                r_hint_p0[0]  <= bus.instr_hint_i;
            end else begin
                r_instr_p0[1] <= bus.instr_i;
                r_hv_p0[1]    <= bus.instr_hint_valid_i;
                r_hint_p0[1]  <= bus.instr_hint_i;
            end
        end
    end

    assign bus.instr_ready_o            = w_ready;
    assign bus.occupancy_o              = r_occ;
    assign bus.dispatch_err_o           = r_err;
    assign bus.dispatched_instr_valid_o = r_disp_vld_p1;
    assign bus.dispatched_instr_o       = r_disp_instr_p1;

endmodule

// File: tb/tb_eu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_eu_dispatch
// Drives eu_dispatch through directed scenarios and a randomized phase and
// compares every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_eu_dispatch;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 64;

    logic clk;
    logic reset_n;

    eu_dispatch_if #(.N_EU(N), .EU_IDX_W(IW), .INSTR_W(DW)) bus ();

    eu_dispatch #(.N_EU(N), .EU_IDX_W(IW), .INSTR_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] instr;
        logic          hv;
        logic [IW-1:0] hint;
    } ent_t;

    ent_t          q[$];
    int            m_rr   = 0;
    logic          m_err  = 1'b0;
    logic [N-1:0]  m_vld  = '0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge reset_n) begin : model
        bit   rdy;
        bit   go;
        bit   pin;
        int   tgt;
        ent_t h;
        ent_t e;
        if (!reset_n) begin
            q.delete();
            m_rr   = 0;
            m_err  = 1'b0;
            m_vld  = '0;
            m_data = '0;
        end else begin
            rdy = (q.size() < 2);
            go  = 1'b0;
            pin = 1'b0;
            tgt = 0;
            h   = '{default: '0};
            if (q.size() > 0) begin
                h = q[0];
                if (h.hv && int'(h.hint) >= N) m_err = 1'b1;
                pin = h.hv && int'(h.hint) < N;
                if (pin) begin
                    tgt = int'(h.hint);
                    go  = bus.eu_ready_i[tgt];
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (!go && bus.eu_ready_i[(m_rr + i) % N]) begin
                            go  = 1'b1;
                            tgt = (m_rr + i) % N;
                        end
                    end
                end
            end
            if (bus.flush_i) begin
                q.delete();
                m_vld = '0;
            end else begin
                if (go) begin
                    void'(q.pop_front());
                    m_vld  = N'(1 << tgt);
                    m_data = h.instr;
                    if (!pin) m_rr = (tgt + 1) % N;
                end else begin
                    m_vld = '0;
                end
                if (bus.instr_valid_i && rdy) begin
                    e.instr = bus.instr_i;
                    e.hv    = bus.instr_hint_valid_i;
                    e.hint  = bus.instr_hint_i;
                    q.push_back(e);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_ready", 64'(bus.instr_ready_o), 64'(q.size() < 2));
            chk("m_occ",   64'(bus.occupancy_o), 64'(q.size()));
            chk("m_vld",   64'(bus.dispatched_instr_valid_o), 64'(m_vld));
            chk("m_data",  bus.dispatched_instr_o, m_data);
            chk("m_err",   64'(bus.dispatch_err_o), 64'(m_err));
            chk("m_onehot", 64'($onehot0(bus.dispatched_instr_valid_o)), 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [DW-1:0] d, input bit hv, input logic [IW-1:0] h);
        bus.instr_valid_i      = v;
        bus.instr_i            = d;
        bus.instr_hint_valid_i = hv;
        bus.instr_hint_i       = h;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.flush_i = 1'b0;
        bus.eu_ready_i = '0;
        drv(0, '0, 0, '0);
        #12;
        chk("rst_occ",  64'(bus.occupancy_o), 64'd0);
        chk("rst_vld",  64'(bus.dispatched_instr_valid_o), 64'd0);
        chk("rst_data", bus.dispatched_instr_o, 64'd0);
        chk("rst_err",  64'(bus.dispatch_err_o), 64'd0);
        #1 reset_n = 1'b1;
        #1 chk("rst_ready", 64'(bus.instr_ready_o), 64'd1);
        cyc();

        // Round-robin stream across all-ready EUs
        bus.eu_ready_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drv(1, 64'hA0 + 64'(i), 0, '0);
            cyc();
            chk("rr_ready", 64'(bus.instr_ready_o), 64'd1);
            if (i == 0) chk("rr_lat", 64'(bus.dispatched_instr_valid_o), 64'd0);
            else begin
                chk("rr_vld",  64'(bus.dispatched_instr_valid_o), 64'(1 << (i - 1)));
                chk("rr_data", bus.dispatched_instr_o, 64'hA0 + 64'(i - 1));
            end
        end
        drv(0, '0, 0, '0);
        cyc();
        chk("rr_vld3", 64'(bus.dispatched_instr_valid_o), 64'h8);
        chk("rr_data3", bus.dispatched_instr_o, 64'hA3);
        cyc();
        chk("rr_idle", 64'(bus.dispatched_instr_valid_o), 64'h0);

        // Backpressure with no ready EU
        bus.eu_ready_i = 4'b0000;
        drv(1, 64'hB0, 0, '0); cyc();
        chk("bp_occ1", 64'(bus.occupancy_o), 64'd1);
        drv(1, 64'hB1, 0, '0); cyc();
        chk("bp_occ2", 64'(bus.occupancy_o), 64'd2);
        chk("bp_rdy0", 64'(bus.instr_ready_o), 64'd0);
        drv(1, 64'hB2, 0, '0); cyc();
        chk("bp_hold", 64'(bus.occupancy_o), 64'd2);
        chk("bp_novld", 64'(bus.dispatched_instr_valid_o), 64'd0);
        bus.eu_ready_i = 4'b1111;
        cyc();
        chk("bp_v0", 64'(bus.dispatched_instr_valid_o), 64'h1);
        chk("bp_d0", bus.dispatched_instr_o, 64'hB0);
        cyc();
        chk("bp_v1", 64'(bus.dispatched_instr_valid_o), 64'h2);
        chk("bp_d1", bus.dispatched_instr_o, 64'hB1);
        chk("bp_occ", 64'(bus.occupancy_o), 64'd1);
        drv(0, '0, 0, '0); cyc();
        chk("bp_v2", 64'(bus.dispatched_instr_valid_o), 64'h4);
        chk("bp_d2", bus.dispatched_instr_o, 64'hB2);

        // Pinned head blocks a younger unpinned entry; rr_ptr untouched
        drv(1, 64'hC0, 0, '0); cyc();
        drv(0, '0, 0, '0); cyc();
        chk("pin_pre", 64'(bus.dispatched_instr_valid_o), 64'h8);
        bus.eu_ready_i = 4'b1011;
        drv(1, 64'hC1, 1, 3'd2); cyc();
        drv(1, 64'hC2, 0, '0); cyc();
        chk("pin_stall", 64'(bus.dispatched_instr_valid_o), 64'h0);
        drv(0, '0, 0, '0); cyc();
        chk("pin_stall2", 64'(bus.dispatched_instr_valid_o), 64'h0);
        chk("pin_occ", 64'(bus.occupancy_o), 64'd2);
        bus.eu_ready_i = 4'b1111;
        cyc();
        chk("pin_v", 64'(bus.dispatched_instr_valid_o), 64'h4);
        chk("pin_d", bus.dispatched_instr_o, 64'hC1);
        cyc();
        chk("pin_rr", 64'(bus.dispatched_instr_valid_o), 64'h1);
        chk("pin_rr_d", bus.dispatched_instr_o, 64'hC2);

        // Out-of-range hint: sticky error, dispatched round-robin
        chk("err_pre", 64'(bus.dispatch_err_o), 64'd0);
        drv(1, 64'hD0, 1, 3'd5); cyc();
        drv(0, '0, 0, '0); cyc();
        chk("err_v", 64'(bus.dispatched_instr_valid_o), 64'h2);
        chk("err_set", 64'(bus.dispatch_err_o), 64'd1);
        drv(1, 64'hD1, 0, '0); cyc();
        drv(0, '0, 0, '0); cyc();
        chk("err_v2", 64'(bus.dispatched_instr_valid_o), 64'h4);
        chk("err_stk", 64'(bus.dispatch_err_o), 64'd1);

        // Flush with a full buffer and a selected dispatch
        bus.eu_ready_i = 4'b0000;
        drv(1, 64'hE0, 0, '0); cyc();
        drv(1, 64'hE1, 0, '0); cyc();
        chk("fl_occ2", 64'(bus.occupancy_o), 64'd2);
        bus.eu_ready_i = 4'b1111;
        bus.flush_i = 1'b1;
        drv(1, 64'hE2, 0, '0); cyc();
        chk("fl_vld", 64'(bus.dispatched_instr_valid_o), 64'h0);
        chk("fl_occ", 64'(bus.occupancy_o), 64'd0);
        bus.flush_i = 1'b0;
        drv(1, 64'hE3, 0, '0); cyc();
        drv(0, '0, 0, '0); cyc();
        chk("fl_rr", 64'(bus.dispatched_instr_valid_o), 64'h8);
        chk("fl_d", bus.dispatched_instr_o, 64'hE3);
        chk("fl_err", 64'(bus.dispatch_err_o), 64'd1);

        // Async reset while a dispatch is on the bus
        drv(1, 64'hF0, 0, '0); cyc();
        drv(0, '0, 0, '0); cyc();
        chk("ar_pre", 64'(bus.dispatched_instr_valid_o), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_vld",  64'(bus.dispatched_instr_valid_o), 64'h0);
        chk("ar_occ",  64'(bus.occupancy_o), 64'd0);
        chk("ar_err",  64'(bus.dispatch_err_o), 64'd0);
        chk("ar_data", bus.dispatched_instr_o, 64'd0);
        #4 reset_n = 1'b1;
        cyc();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            bus.eu_ready_i = N'($urandom_range(0, 15));
            bus.flush_i    = ($urandom_range(0, 19) == 0);
            drv(($urandom_range(0, 9) < 7), {$urandom(), $urandom()},
                ($urandom_range(0, 3) == 0), IW'($urandom_range(0, 7)));
            cyc();
        end
        bus.flush_i = 1'b0;
        bus.eu_ready_i = 4'b1111;
        drv(0, '0, 0, '0);
        for (int c = 0; c < 5; c++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eu_dispatch.md
Name: eu_dispatch

Overview:
- Sits directly upstream of the execution units and drives each unit's dispatched_instr / dispatched_instr_valid inputs.
- Takes renamed instructions from the front-end stream through a 2-entry skid buffer.
- Sends at most one instruction per cycle to one EU: the pinned EU if the instruction carries a hint, otherwise round-robin among ready EUs.
- Provides a flush path and a sticky error flag for malformed hints.

Parameters:
- N_EU, 4, number of execution units served
- EU_IDX_W, 2, width of EU index; must be at least clog2(N_EU)
- INSTR_W, 64, width of a packed iqueue entry

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instr_i  in  INSTR_W  incoming packed instruction
- instr_hint_valid_i  in  1  instruction is pinned to a specific EU
- instr_hint_i  in  EU_IDX_W  index of the pinned EU
- instr_valid_i  in  1  upstream has an instruction
- instr_ready_o  out  1  buffer can accept an instruction this cycle
- flush_i  in  1  synchronous flush, discards buffered and pending work
- eu_ready_i  in  N_EU  bit k high: EU k can accept a dispatch in the next cycle
- dispatched_instr_o  out  INSTR_W  shared instruction bus to all EUs
- dispatched_instr_valid_o  out  N_EU  one-hot; bit k qualifies the bus for EU k
- occupancy_o  out  2  number of buffered entries (0..2)
- dispatch_err_o  out  1  sticky; an out-of-range hint was seen

Behaviour:
- Reset (async, reset_n low): buffer empty, occupancy_o=0, rr_ptr=0, dispatched_instr_valid_o=0, dispatched_instr_o=0, dispatch_err_o=0.
  - instr_ready_o=1 once reset deasserts.
  - Reset mid-dispatch drops everything immediately.
- Buffer: 2-entry FIFO of {instr, hint_valid, hint}.
  - instr_ready_o = (occupancy < 2). It depends only on registered state and never on instr_valid_i.
  - Push occurs on instr_valid_i & instr_ready_o at a clock edge.
- Selection (combinational, head entry only, head must be valid):
  - Hint valid and hint < N_EU: target = hint. Dispatch only if eu_ready_i[hint]; otherwise stall. A pinned head blocks younger entries (in-order).
  - Hint valid and hint >= N_EU: set dispatch_err_o (sticky until reset) and treat the entry as unpinned.
  - Unpinned: target = first k with eu_ready_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod N_EU. No ready EU means stall.
  - Pinned dispatches do not move rr_ptr.
- Dispatch at edge:
  - Head is popped.
  - dispatched_instr_o and dispatched_instr_valid_o (one-hot at target) are registered and visible for exactly one cycle after the selection cycle.
  - For unpinned dispatches, rr_ptr <= (target+1) mod N_EU.
  - With no dispatch, valid_o=0 and dispatched_instr_o holds its last value.
- Latency: instruction pushed at edge t, all EUs ready → valid_o high in the cycle after edge t+1 (2 edges, push to output).
- EU contract: if eu_ready_i[k] is high in cycle c, EU k must accept a valid arriving in cycle c+1. Dropping ready affects selection in the same cycle.
- Simultaneous push and pop:
  - occupancy 1 → stays 1.
  - occupancy 2 → no push (ready low), pop to 1.
  - occupancy 0 → push only; selection sees the entry next cycle.
- flush_i at an edge:
  - Buffer cleared (occupancy 0). Any push in the same cycle is discarded.
  - dispatched_instr_valid_o is forced to 0 in the following cycle, even if a dispatch was selected.
  - rr_ptr and dispatch_err_o are kept.
- Invariants:
  - dispatched_instr_valid_o is always one-hot or zero.
  - occupancy_o never exceeds 2.
  - No instruction is duplicated or reordered.

Test Plan:
- Reset then stream A,B,C,D unpinned, eu_ready_i=4'b1111 → valids 0001,0010,0100,1000 on successive cycles; first valid 2 edges after A's push; instr_ready_o stays 1.
- eu_ready_i=4'b0000, push 3 instructions back-to-back → occupancy_o 1,2; instr_ready_o=0 after the second push; third held upstream; no valid until ready returns, then dispatch in order.
- Head pinned hint=2 with eu_ready_i=4'b1011; second entry unpinned → both stall until eu_ready_i[2]=1; then head goes to EU2 (valid 0100) and rr_ptr is unchanged.
- Unpinned instruction with hint_valid=1, hint=5, N_EU=4 → dispatch_err_o=1 and stays 1 after further traffic; the instruction dispatches round-robin.
- occupancy 2 with a dispatch selected and flush_i=1 at that edge → next cycle valid_o=0000, occupancy_o=0; a subsequent push dispatches normally from the retained rr_ptr.
- Assert reset_n low while valid_o is high → valid_o=0, occupancy_o=0, dispatch_err_o=0 immediately, without waiting for a clock edge.
